// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - pipelined instruction decode stage with skid buffer
// Decodes one instruction per cycle into a registered bundle; illegal instructions are counted.
module instr_decode_stage #(
    parameter int XLEN  = 32,
    parameter int ID_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ir,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ID_W-1:0]  out_id,
    output logic [XLEN-1:0]  out_rs,
    output logic [XLEN-1:0]  out_rt,
    output logic [XLEN-1:0]  out_rd,
    output logic [XLEN-1:0]  out_wreg,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_shamt,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      wreg;
        logic [XLEN-1:0] imm;
        logic [4:0]      shamt;
        logic [25:0]     target;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {IMM_NONE, IMM_SEXT, IMM_ZEXT} imm_kind_t;
    typedef enum logic [1:0] {WR_NONE, WR_RD, WR_RT, WR_RA} wreg_kind_t;

    bundle_t    dec;
    bundle_t    out_q;
    bundle_t    skid_q;
    logic       skid_valid;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] id5;
    imm_kind_t  imm_kind;
    wreg_kind_t wreg_kind;
    logic       in_xfer;
    logic       out_xfer;

    assign op = in_ir[31:26];
    assign fn = in_ir[5:0];

    always_comb begin
        id5       = 5'd0;
        imm_kind  = IMM_NONE;
        wreg_kind = WR_NONE;
        case (op)
            6'b000001: begin
                wreg_kind = WR_RD;
                case (fn)
                    6'b000000: id5 = 5'd1;
                    6'b000001: id5 = 5'd2;
                    6'b000010: id5 = 5'd3;
                    6'b000011: id5 = 5'd4;
                    6'b000100: id5 = 5'd5;
                    6'b000101: id5 = 5'd6;
                    default: begin
                        id5       = 5'd0;
                        wreg_kind = WR_NONE;
                    end
                endcase
            end
            6'b001000: begin id5 = 5'd7;  imm_kind = IMM_SEXT; wreg_kind = WR_RT; end
            6'b001001: begin id5 = 5'd8;  imm_kind = IMM_SEXT; wreg_kind = WR_RT; end
            6'b001100: begin id5 = 5'd9;  imm_kind = IMM_ZEXT; wreg_kind = WR_RT; end
            6'b100011: begin id5 = 5'd10; imm_kind = IMM_SEXT; wreg_kind = WR_RT; end
            6'b101011: begin id5 = 5'd11; imm_kind = IMM_SEXT; end
            6'b000100: begin id5 = 5'd12; imm_kind = IMM_SEXT; end
            6'b000101: begin id5 = 5'd13; imm_kind = IMM_SEXT; end
            6'b000010: id5 = 5'd14;
            6'b000011: begin id5 = 5'd15; wreg_kind = WR_RA; end
            6'b010101: id5 = 5'd16;
            default:   id5 = 5'd0;
        endcase

        // Register fields are extracted unconditionally; only imm/wreg depend on the type.
        dec         = '0;
        dec.id      = ID_W'(id5);
        dec.illegal = (id5 == 5'd0);
        dec.rs      = in_ir[25:21];
        dec.rt      = in_ir[20:16];
        dec.rd      = in_ir[15:11];
        dec.shamt   = in_ir[10:6];
        dec.target  = in_ir[25:0];
        dec.pc      = in_pc;
        case (imm_kind)
            IMM_SEXT: dec.imm = {{(XLEN-16){in_ir[15]}}, in_ir[15:0]};
            IMM_ZEXT: dec.imm = {{(XLEN-16){1'b0}}, in_ir[15:0]};
            default:  dec.imm = '0;
        endcase
        case (wreg_kind)
            WR_RD:   dec.wreg = in_ir[15:11];
            WR_RT:   dec.wreg = in_ir[20:16];
            WR_RA:   dec.wreg = 5'd31;
            default: dec.wreg = 5'd0;
        endcase
    end

    // in_ready derives only from skid state, never from out_ready.
    assign in_ready = !skid_valid && !rst;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_xfer || !out_valid) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (in_xfer && !flush && dec.illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    assign out_id      = out_q.id;
    assign out_rs      = XLEN'(out_q.rs);
    assign out_rt      = XLEN'(out_q.rt);
    assign out_rd      = XLEN'(out_q.rd);
    assign out_wreg    = XLEN'(out_q.wreg);
    assign out_imm     = out_q.imm;
    assign out_shamt   = out_q.shamt;
    assign out_target  = XLEN'(out_q.target);
    assign out_pc      = out_q.pc;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - directed table-driven bench for instr_decode_stage
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ir;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_id;
    logic [31:0] out_rs, out_rt, out_rd, out_wreg, out_imm, out_target, out_pc;
    logic [4:0]  out_shamt;
    logic        out_illegal;
    logic [1:0]  illegal_cnt;

    int checks   = 0;
    int failures = 0;

    instr_decode_stage #(.XLEN(32), .ID_W(8), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_wreg(out_wreg), .out_imm(out_imm), .out_shamt(out_shamt),
        .out_target(out_target), .out_pc(out_pc), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ir;
        logic [7:0]  id;
        logic [31:0] wreg;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t vec [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_both(input logic [31:0] a, input logic [31:0] b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ir     = a;
        step();
        in_ir     = b;
        step();
        in_valid  = 1'b0;
    endtask

    int exp_cnt;

    initial begin
        vec[0]  = '{32'h05EFFFC0, 8'd1,  32'd31, 32'h00000000, 1'b0};
        vec[1]  = '{32'h210FFFFF, 8'd7,  32'd15, 32'hFFFFFFFF, 1'b0};
        vec[2]  = '{32'h310FFFFF, 8'd9,  32'd15, 32'h0000FFFF, 1'b0};
        vec[3]  = '{32'h24CF0000, 8'd8,  32'd15, 32'h00000000, 1'b0};
        vec[4]  = '{32'h05EFFFC1, 8'd2,  32'd31, 32'h00000000, 1'b0};
        vec[5]  = '{32'h05EFFFC2, 8'd3,  32'd31, 32'h00000000, 1'b0};
        vec[6]  = '{32'h05EFFFC3, 8'd4,  32'd31, 32'h00000000, 1'b0};
        vec[7]  = '{32'h05EFFFC4, 8'd5,  32'd31, 32'h00000000, 1'b0};
        vec[8]  = '{32'h05EFFFC5, 8'd6,  32'd31, 32'h00000000, 1'b0};
        vec[9]  = '{32'h8D098004, 8'd10, 32'd9,  32'hFFFF8004, 1'b0};
        vec[10] = '{32'hAC227FFF, 8'd11, 32'd0,  32'h00007FFF, 1'b0};
        vec[11] = '{32'h10000010, 8'd12, 32'd0,  32'h00000010, 1'b0};
        vec[12] = '{32'h1400FFFE, 8'd13, 32'd0,  32'hFFFFFFFE, 1'b0};
        vec[13] = '{32'h08001234, 8'd14, 32'd0,  32'h00000000, 1'b0};
        vec[14] = '{32'h0C000100, 8'd15, 32'd31, 32'h00000000, 1'b0};
        vec[15] = '{32'h54000000, 8'd16, 32'd0,  32'h00000000, 1'b0};
        vec[16] = '{32'hFC000000, 8'd0,  32'd0,  32'h00000000, 1'b1};
        vec[17] = '{32'h05EFFFC6, 8'd0,  32'd0,  32'h00000000, 1'b1};
        vec[18] = '{32'h3C00FFFF, 8'd0,  32'd0,  32'h00000000, 1'b1};
        vec[19] = '{32'h210F8000, 8'd7,  32'd15, 32'hFFFF8000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_ir = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("post_rst_id", {24'b0, out_id}, 32'd0);
        chk("post_rst_imm", out_imm, 32'd0);
        chk("post_rst_cnt", {30'b0, illegal_cnt}, 32'd0);

        exp_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_ir    = vec[i].ir;
            in_pc    = 32'h1000 + 32'(i * 4);
            step();
            in_valid = 1'b0;
            if (vec[i].ill && exp_cnt < 3) exp_cnt++;
            chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("v%0d_id", i), {24'b0, out_id}, {24'b0, vec[i].id});
            chk($sformatf("v%0d_illegal", i), {31'b0, out_illegal}, {31'b0, vec[i].ill});
            chk($sformatf("v%0d_wreg", i), out_wreg, vec[i].wreg);
            chk($sformatf("v%0d_imm", i), out_imm, vec[i].imm);
            chk($sformatf("v%0d_rs", i), out_rs, {27'b0, vec[i].ir[25:21]});
            chk($sformatf("v%0d_rt", i), out_rt, {27'b0, vec[i].ir[20:16]});
            chk($sformatf("v%0d_rd", i), out_rd, {27'b0, vec[i].ir[15:11]});
            chk($sformatf("v%0d_shamt", i), {27'b0, out_shamt}, {27'b0, vec[i].ir[10:6]});
            chk($sformatf("v%0d_target", i), out_target, {6'b0, vec[i].ir[25:0]});
            chk($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d_cnt", i), {30'b0, illegal_cnt}, 32'(exp_cnt));
        end
        step();
        chk("idle_valid", {31'b0, out_valid}, 32'd0);

        // Stall: first held at output, second into skid, then drained in order.
        fill_both(32'h24CF0000, 32'h05EFFFC1);
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_id", {24'b0, out_id}, 32'd8);
        step();
        chk("stall_hold_id", {24'b0, out_id}, 32'd8);
        out_ready = 1'b1;
        step();
        chk("drain_valid", {31'b0, out_valid}, 32'd1);
        chk("drain_id", {24'b0, out_id}, 32'd2);
        chk("drain_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("drain_empty", {31'b0, out_valid}, 32'd0);

        // Back-to-back with out_ready high: no bubble.
        in_valid = 1'b1;
        in_ir = 32'h210FFFFF;
        step();
        in_ir = 32'h310FFFFF;
        step();
        in_valid = 1'b0;
        chk("b2b_valid", {31'b0, out_valid}, 32'd1);
        chk("b2b_id", {24'b0, out_id}, 32'd9);
        step();

        // Counter saturation from a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_ir = 32'hFC000000;
        step();
        chk("cnt_first", {30'b0, illegal_cnt}, 32'd1);
        chk("cnt_first_ill", {31'b0, out_illegal}, 32'd1);
        for (int k = 0; k < 4; k++) step();
        in_valid = 1'b0;
        chk("cnt_sat", {30'b0, illegal_cnt}, 32'd3);
        step();

        // Flush with both entries full and a same-cycle input.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        fill_both(32'h210FFFFF, 32'h310FFFFF);
        flush = 1'b1;
        in_valid = 1'b1;
        in_ir = 32'hFC000000;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_cnt", {30'b0, illegal_cnt}, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("flush_quiet%0d", k), {31'b0, out_valid}, 32'd0);
        end

        // Asynchronous reset while stalled with both entries full.
        fill_both(32'hFC000000, 32'hFC000000);
        chk("pre_rst_cnt", {30'b0, illegal_cnt}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", {31'b0, out_valid}, 32'd0);
        chk("async_cnt", {30'b0, illegal_cnt}, 32'd0);
        chk("async_in_ready", {31'b0, in_ready}, 32'd0);
        chk("async_id", {24'b0, out_id}, 32'd0);
        step();
        rst = 1'b0;
        step();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_ir = 32'h210FFFFF;
        step();
        in_valid = 1'b0;
        chk("resume_valid", {31'b0, out_valid}, 32'd1);
        chk("resume_id", {24'b0, out_id}, 32'd7);
        chk("resume_imm", out_imm, 32'hFFFFFFFF);
        step();
        chk("resume_empty", {31'b0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Pipelined, parametrised successor to the combinational instruction decoder.
- Accepts one 32-bit instruction per cycle through a valid/ready handshake and produces a registered decoded bundle one cycle later: ID, register fields, destination, extended immediate, shift amount and jump target.
- A 2-entry skid buffer decouples the fetch side from the execute side.
- Adds flush, illegal-instruction detection and a saturating illegal counter.
- Sits between the instruction fetch stage and the execute/register-read stage.

Parameters:
- XLEN, 32, width of out_rs/out_rt/out_rd/out_wreg/out_imm/out_target/pc ports (zero-extended fields).
- ID_W, 8, width of the decoded instruction ID.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  instruction on in_ir/in_pc is valid
- in_ready  out  1  stage can accept an instruction
- in_ir  in  32  instruction word
- in_pc  in  XLEN  PC of instruction
- flush  in  1  discard all held and incoming instructions
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  consumer accepts bundle
- out_id  out  ID_W  decoded instruction ID (0 = illegal)
- out_rs, out_rt, out_rd  out  XLEN  ir[25:21], ir[20:16], ir[15:11], zero-extended
- out_wreg  out  XLEN  destination register index
- out_imm  out  XLEN  extended ir[15:0]
- out_shamt  out  5  ir[10:6]
- out_target  out  XLEN  ir[25:0] zero-extended
- out_pc  out  XLEN  registered in_pc
- out_illegal  out  1  bundle is an illegal instruction
- illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted

Behaviour:
- Decode table, op = ir[31:26], fn = ir[5:0]:
  - op 000001 R-type: fn 000000 add=1, 000001 sub=2, 000010 and=3, 000011 or=4, 000100 sll=5, 000101 srl=6. out_wreg = rd.
  - op 001000 addi=7, 001001 addiu=8: sign-extended imm, out_wreg = rt.
  - op 001100 andi=9: zero-extended imm, out_wreg = rt.
  - op 100011 lw=10: sign-extended imm, out_wreg = rt.
  - op 101011 sw=11, 000100 beq=12, 000101 bne=13: sign-extended imm, out_wreg = 0.
  - op 000010 j=14: out_wreg = 0.
  - op 000011 jal=15: out_wreg = 31.
  - op 010101 halt=16: out_wreg = 0.
  - Any other op, or R-type with any other fn: ID 0, out_illegal = 1, out_wreg = 0, imm = 0.
- out_imm for J-type and R-type is 0. Field outputs are always extracted, regardless of type.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Data is held stable while out_valid & !out_ready.
- Storage: output register plus one skid entry.
  - in_ready = !skid_full, registered; it does not depend combinationally on out_ready.
  - Latency is 1 cycle from input transfer to out_valid when the stage is empty.
- Stall: if the output is full and not accepted and a transfer arrives, it goes to skid. in_ready then drops the next cycle.
- Drain: when the output is accepted and skid is full, skid moves to the output the same edge. in_ready rises the next cycle.
- Simultaneous: output accepted and input transferred with skid empty → new bundle loads the output. out_valid stays 1 with no bubble.
- flush:
  - Clears out_valid and skid the next edge.
  - Any same-cycle input transfer is dropped and not counted.
  - in_ready = 1 after the flush edge.
- illegal_cnt:
  - Increments when an illegal instruction is accepted at the input and flush = 0.
  - Saturates at all-ones with no wrap.
  - Not cleared by flush.
- Reset (async, any time, including mid-stall):
  - out_valid = 0, in_ready = 1 after deassert (0 while rst is high), skid empty, illegal_cnt = 0.
  - All data outputs = 0, out_id = 0, out_illegal = 0.
- out_illegal and out_id are meaningful only while out_valid = 1.

Test Plan:
- Reset then in_ir=0x05EFFFC0, out_ready=1 → next cycle out_valid=1, id=1, rs=15, rt=15, rd=31, wreg=31, shamt=31, imm=0.
- in_ir=0x210FFFFF (addi) → id=7, rs=8, rt=15, wreg=15, imm=0xFFFFFFFF. in_ir=0x310FFFFF (andi) → id=9, imm=0x0000FFFF.
- out_ready=0, push 0x24CF0000 then 0x05EFFFC1 → the first is held at the output (id=8), the second goes to skid, and in_ready=0. Raise out_ready → id=8 then id=2 on consecutive cycles with no loss or duplication.
- in_ir=0xFC000000 → out_id=0, out_illegal=1, illegal_cnt=1. With CNT_W=2, push 5 illegal instructions → illegal_cnt saturates at 3.
- Fill output and skid, assert flush with in_valid=1 → out_valid=0 next cycle, in_ready=1, and nothing emerges afterwards.
- Assert rst mid-stall with both entries full → out_valid=0, illegal_cnt=0 immediately (asynchronous); normal decode resumes after deassert.
